muldiv_iter: RTL and testbench
==============================

# muldiv_iter

Parametrised iterative multiply/divide unit implementing the full RV32M/RV64M operation set.
- Sits beside the ex stage in place of the divide-only unit.
- ex stalls the pipeline while `busy_o` is high and writes `result_o` to `reg_waddr_o` on `ready_o`.
- Uses one shared shift datapath: shift-add multiply and restoring divide, one result bit per cycle.
- Divide special cases complete early.
- A pipeline flush (jump or interrupt) aborts the operation in flight.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (32 or 64).
- `REG_ADDR_W`, 5, destination register tag width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: request; sampled only in IDLE.
- `op_i` in 3: funct3 encoding.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a_i` in XLEN: rs1 value / dividend.
- `op_b_i` in XLEN: rs2 value / divisor.
- `reg_waddr_i` in REG_ADDR_W: destination tag, captured at start.
- `flush_i` in 1: abort the current operation.
- `busy_o` out 1: high in CALC and DONE.
- `ready_o` out 1: one-cycle pulse in DONE.
- `result_o` out XLEN: result, valid from `ready_o` until the next accepted start.
- `reg_waddr_o` out REG_ADDR_W: tag captured at start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start_i && !flush_i` latches op, operands and tag.
  - Goes to DONE for divide special cases, otherwise to CALC.
- CALC runs for exactly XLEN cycles, then goes to DONE.
- DONE asserts `ready_o` and `busy_o`, then goes to IDLE.
- `flush_i` in any state forces IDLE on the next edge.
  - No `ready_o` is issued for the aborted operation.
  - `result_o` and `reg_waddr_o` keep their previous values.
- `start_i` outside IDLE is ignored; there is no queueing.
- Sign handling:
  - Operand a is signed for MULH, MULHSU, DIV and REM.
  - Operand b is signed for MULH, DIV and REM.
  - Magnitudes are taken at start; the sign is fixed up in the DONE transition.
- Multiply:
  - 2·XLEN-bit accumulator.
  - Product sign = sign_a XOR sign_b, negated over the full 2·XLEN bits.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - XLEN-bit partial remainder plus one guard bit.
  - Quotient is negated if sign_a XOR sign_b.
  - Remainder takes the sign of the dividend.
- Special cases, skipping CALC:
  - Divisor zero: quotient = all ones, remainder = dividend.
  - Signed overflow (MIN / −1): quotient = MIN, remainder = 0.
- Reset, asynchronous and immediate:
  - State = IDLE.
  - All outputs and internal registers = 0.

## Timing
- Start accepted at edge T.
- Normal operation:
  - CALC occupies cycles T+1 … T+XLEN.
  - DONE, with `ready_o` = 1, is cycle T+XLEN+1.
  - Latency is XLEN+1 cycles.
- Special-case divide: DONE at T+1, latency 1.
- `busy_o`:
  - Rises in the cycle after acceptance.
  - Falls in the cycle after DONE.
  - Is combinational from state, not from `start_i`.
- Earliest next start is at the edge ending DONE+1, i.e. one cycle after `ready_o`.
- `result_o` and `reg_waddr_o` update at the edge entering DONE and are stable thereafter.
- Flush:
  - Flush in cycle C gives IDLE and `busy_o` = 0 in C+1.
  - Flush and `start_i` in the same IDLE cycle: flush wins and the start is dropped.
  - Flush in DONE: `ready_o` is still visible that cycle; ex must gate the writeback with its own flush.

## Structure
- Package `muldiv_pkg` holds:
  - enum `muldiv_op_e` (the eight funct3 codes);
  - enum `muldiv_state_e` (IDLE, CALC, DONE);
  - helper functions `is_div(op)`, `a_signed(op)`, `b_signed(op)`.
- Single module; no sub-module is warranted.
- The shift/add and subtract share one XLEN+1-bit adder.
- Cycle count uses a $clog2(XLEN)+1-bit down-counter.

## Test plan
All values are for XLEN = 32.
- MUL 7 × 0xFFFFFFFD, start at T:
  - `ready_o` at T+33 only, `result_o` = 0xFFFFFFEB;
  - `reg_waddr_o` equals the tag given at start.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
- REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
- DIVU 100 / 7 → 14, `ready_o` at T+33.
- REMU 100 / 7 → 2, `ready_o` at T+33.
- Special cases, each with `ready_o` at T+1:
  - DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Flush at T+10:
  - `busy_o` = 0 at T+11 and no `ready_o` for that operation;
  - a new start at T+11 completes normally at T+44.
- Start pulses during busy are ignored.
- Async `rst` asserted mid-CALC, between clock edges:
  - outputs are 0 immediately;
  - after deassert, the first start gives a correct result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and decode helpers for the iterative multiply/divide unit.
//   muldiv_op_e    - funct3 encodings of the RV32M/RV64M operations
//   muldiv_state_e - controller states
//   is_div/a_signed/b_signed - per-operation decode helpers
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } muldiv_state_e;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic a_signed(input muldiv_op_e op);
        return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic b_signed(input muldiv_op_e op);
        return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M/RV64M multiply/divide unit, one result bit per cycle.
//   Shift-add multiply and restoring divide share a single XLEN+1-bit adder. Operands are
//   reduced to magnitudes at start; the sign is applied on the edge entering DONE.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start_i           - request, sampled only in IDLE
//   op_i              - funct3 operation code (see muldiv_op_e)
//   op_a_i, op_b_i    - rs1 (dividend) and rs2 (divisor)
//   reg_waddr_i       - destination tag, captured at start
//   flush_i           - abort the operation in flight
//   busy_o            - high in CALC and DONE
//   ready_o           - one-cycle pulse in DONE
//   result_o          - result, updated on the edge entering DONE
//   reg_waddr_o       - tag of the completed operation, updated with result_o
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       op_a_i,
    input  logic [XLEN-1:0]       op_b_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [XLEN-1:0]       result_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e         state_q, state_d;
    muldiv_op_e            op_q, op_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // hi: product high half / partial remainder; lo: multiplier / dividend-then-quotient.
    logic [XLEN-1:0]       hi_q, hi_d;
    logic [XLEN-1:0]       lo_q, lo_d;
    logic [XLEN-1:0]       b_q, b_d;
    logic                  neg_q, neg_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [REG_ADDR_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;

    // Start-time operand decode.
    muldiv_op_e      op_in;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        op_in       = muldiv_op_e'(op_i);
        sign_a      = a_signed(op_in) & op_a_i[XLEN-1];
        sign_b      = b_signed(op_in) & op_b_i[XLEN-1];
        mag_a       = sign_a ? -op_a_i : op_a_i;
        mag_b       = sign_b ? -op_b_i : op_b_i;
        div_by_zero = is_div(op_in) && (op_b_i == '0);
        div_ovf     = is_div(op_in) && b_signed(op_in) && (op_a_i == MinVal) && (op_b_i == '1);
        // On overflow the dividend is MIN, so it doubles as the quotient.
        special_res = '0;
        unique case (op_in)
            OpDiv, OpDivu: special_res = div_by_zero ? '1 : op_a_i;
            OpRem, OpRemu: special_res = div_by_zero ? op_a_i : '0;
            default:       special_res = '0;
        endcase
    end

    // Shared adder: multiply adds b to the high half when the multiplier LSB is set;
    // divide subtracts b (two's complement) from the shifted partial remainder.
    logic [XLEN:0]   add_a, add_b, add_sum;
    logic            add_cin;
    logic            q_bit;
    logic [XLEN-1:0] step_hi, step_lo;

    always_comb begin
        if (is_div(op_q)) begin
            add_a   = {hi_q, lo_q[XLEN-1]};
            add_b   = {1'b1, ~b_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, hi_q};
            add_b   = lo_q[0] ? {1'b0, b_q} : '0;
            add_cin = 1'b0;
        end
        add_sum = add_a + add_b + {{XLEN{1'b0}}, add_cin};

        // Non-negative difference means the divisor fits: keep it and emit a 1.
        q_bit = ~add_sum[XLEN];
        if (is_div(op_q)) begin
            step_hi = q_bit ? add_sum[XLEN-1:0] : add_a[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], q_bit};
        end else begin
            step_hi = add_sum[XLEN:1];
            step_lo = {add_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the value produced by the final iteration.
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -step_lo : step_lo;
        rem_fix  = neg_rem_q ? -step_hi : step_hi;
        final_res = '0;
        unique case (op_q)
            OpMul:                      final_res = prod_fix[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu:  final_res = prod_fix[2*XLEN-1:XLEN];
            OpDiv, OpDivu:              final_res = quo_fix;
            OpRem, OpRemu:              final_res = rem_fix;
            default:                    final_res = '0;
        endcase
    end

    // Controller and datapath next state.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        tag_d     = tag_q;
        result_d  = result_q;
        waddr_d   = waddr_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !flush_i) begin
                    op_d      = op_in;
                    hi_d      = '0;
                    lo_d      = mag_a;
                    b_d       = mag_b;
                    neg_d     = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    tag_d     = reg_waddr_i;
                    cnt_d     = CNT_W'(XLEN - 1);
                    if (div_by_zero || div_ovf) begin
                        state_d  = StDone;
                        result_d = special_res;
                        waddr_d  = reg_waddr_i;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d  = StDone;
                    result_d = final_res;
                    waddr_d  = tag_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // An aborted operation never reaches the visible result registers.
        if (flush_i) begin
            state_d  = StIdle;
            result_d = result_q;
            waddr_d  = waddr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= OpMul;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
            waddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            waddr_q   <= waddr_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign ready_o     = (state_q == StDone);
    assign result_o    = result_q;
    assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed-vector bench for muldiv_iter (XLEN = 32) with a transaction-level
// reference model checked every cycle, plus literal expectations for the listed vectors.
module tb_muldiv_iter;

    localparam logic [31:0] MinVal = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    int checks = 0;
    int errors = 0;

    muldiv_iter #(
        .XLEN       (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .result_o    (result_o),
        .reg_waddr_o (reg_waddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result straight from the RV32M definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, ub_s;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib, iq;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ua   = {32'h0, a};
        ub   = {32'h0, b};
        ub_s = {32'h0, b};
        ia   = a;
        ib   = b;
        p    = '0;
        iq   = 0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub_s; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MinVal && b == 32'hFFFF_FFFF) return MinVal;
                iq = ia / ib;
                return iq;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MinVal && b == 32'hFFFF_FFFF) return 32'h0;
                iq = ia % ib;
                return iq;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        logic signed_div;
        signed_div = (op == 3'd4) || (op == 3'd6);
        if (op[2] && (b == 0 || (signed_div && a == MinVal && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Reference model: cycles left in the current operation (last one is DONE) and the
    // values result_o / reg_waddr_o must show.
    int          m_cnt = 0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_tag = '0;
    logic [31:0] m_pend_res = '0;
    logic [4:0]  m_pend_tag = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cnt = 0;
                m_res = '0;
                m_tag = '0;
            end else if (m_cnt == 0) begin
                if (start_i && !flush_i) begin
                    m_pend_res = ref_result(op_i, op_a_i, op_b_i);
                    m_pend_tag = reg_waddr_i;
                    m_cnt      = ref_latency(op_i, op_a_i, op_b_i);
                    if (m_cnt == 1) begin
                        m_res = m_pend_res;
                        m_tag = m_pend_tag;
                    end
                end
            end else if (flush_i) begin
                m_cnt = 0;
            end else begin
                m_cnt--;
                if (m_cnt == 1) begin
                    m_res = m_pend_res;
                    m_tag = m_pend_tag;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cyc_busy", 64'(busy_o), 64'(m_cnt > 0));
            check("cyc_ready", 64'(ready_o), 64'(m_cnt == 1));
            check("cyc_result", 64'(result_o), 64'(m_res));
            check("cyc_waddr", 64'(reg_waddr_o), 64'(m_tag));
        end
    end

    // Drive a request in the current cycle; it is accepted on the coming edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag);
        op_i        = op;
        op_a_i      = a;
        op_b_i      = b;
        reg_waddr_i = tag;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Wait for ready_o, checking its cycle offset from acceptance and the delivered values.
    // poke_at > 0 raises a stray start request at that cycle offset.
    task automatic wait_ready(input string name, input int exp_lat, input logic [31:0] exp_res,
                              input logic [4:0] exp_tag, input int poke_at);
        int n    = 0;
        bit seen = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (poke_at > 0 && n == poke_at) begin
                op_i        = 3'd0;
                op_a_i      = 32'h0000_0003;
                op_b_i      = 32'h0000_0005;
                reg_waddr_i = 5'h1F;
                start_i     = 1'b1;
            end else if (poke_at > 0 && n == poke_at + 1) begin
                start_i = 1'b0;
            end
            if (ready_o) seen = 1;
        end
        start_i = 1'b0;
        check({name, "_latency"}, 64'(seen ? n : -1), 64'(exp_lat));
        check({name, "_result"}, 64'(result_o), 64'(exp_res));
        check({name, "_waddr"}, 64'(reg_waddr_o), 64'(exp_tag));
        @(negedge clk);
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp_res,
                         input int exp_lat);
        start_op(op, a, b, tag);
        wait_ready(name, exp_lat, exp_res, tag, 0);
    endtask

    // Extra directed vectors checked against the model only.
    logic [2:0]  v_op [10] = '{3'd1, 3'd0, 3'd4, 3'd6, 3'd4, 3'd5, 3'd6, 3'd4, 3'd6, 3'd2};
    logic [31:0] v_a  [10] = '{32'hFFFF_FFFE, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FF9C,
                               32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0007,
                               32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] v_b  [10] = '{32'h0000_0003, 32'h9ABC_DEF0, 32'h0000_0002, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000,
                               32'h0000_0000, 32'h7FFF_FFFF};

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        flush_i     = 1'b0;
        op_i        = '0;
        op_a_i      = '0;
        op_b_i      = '0;
        reg_waddr_i = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_waddr", 64'(reg_waddr_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("mul", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 33);
        do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 33);
        do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 33);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, 33);
        do_op("div", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7, 32'hFFFF_FFFD, 33);
        do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8, 32'hFFFF_FFFF, 33);
        do_op("divu", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 33);
        do_op("remu", 3'd7, 32'd100, 32'd7, 5'd10, 32'd2, 33);
        do_op("divu_z", 3'd5, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
        do_op("remu_z", 3'd7, 32'd5, 32'd0, 5'd12, 32'd5, 1);
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0, 1);

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), v_op[i], v_a[i], v_b[i], 5'(i + 16),
                  ref_result(v_op[i], v_a[i], v_b[i]), ref_latency(v_op[i], v_a[i], v_b[i]));
        end

        // Flush at T+10, restart at T+11, completion at T+44.
        start_op(3'd5, 32'd1000, 32'd3, 5'd20);
        for (int n = 1; n <= 10; n++) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_keep_result", 64'(result_o), 64'(ref_result(v_op[9], v_a[9], v_b[9])));
        start_op(3'd7, 32'd1000, 32'd3, 5'd21);
        wait_ready("after_flush", 33, 32'd1, 5'd21, 0);

        // Stray start while busy is ignored.
        start_op(3'd5, 32'd100, 32'd7, 5'd22);
        wait_ready("busy_start", 33, 32'd14, 5'd22, 5);
        @(negedge clk);
        check("busy_start_idle", 64'(busy_o), 64'd0);

        // Flush and start in the same idle cycle: the start is dropped.
        op_i    = 3'd0;
        op_a_i  = 32'd9;
        op_b_i  = 32'd9;
        start_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 64'(busy_o), 64'd0);

        // Asynchronous reset mid-CALC.
        start_op(3'd0, 32'd6, 32'd7, 5'd23);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_ready", 64'(ready_o), 64'd0);
        check("arst_result", 64'(result_o), 64'd0);
        check("arst_waddr", 64'(reg_waddr_o), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        do_op("after_rst", 3'd0, 32'd6, 32'd7, 5'd24, 32'd42, 33);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
